regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_pkg.sv | 27 ++
 rtl/regfile_sb_cell.sv | 36 +++
 rtl/regfile_sb.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/regfile_sb_pkg.sv
// ----------------------------------------------------------------------------
// regfile_sb_pkg
// Shared register definitions for the scoreboarded register file: the
// architectural register index names and the default geometry.
// No ports.
// ----------------------------------------------------------------------------
package regfile_sb_pkg;

    localparam int NREG_DEFAULT = 10;
    localparam int W_DEFAULT    = 64;
    localparam int SELW_DEFAULT = 4;

    // Architectural register indices.
    typedef enum logic [3:0] {
        RAX = 4'd0,
        RDI = 4'd1,
        RSI = 4'd2,
        RDX = 4'd3,
        RCX = 4'd4,
        RBP = 4'd5,
        RSP = 4'd6,
        RBX = 4'd7,
        R8  = 4'd8,
        R9  = 4'd9
    } reg_idx_e;

endpackage : regfile_sb_pkg

// File: rtl/regfile_sb_cell.sv
// ----------------------------------------------------------------------------
// regfile_sb_cell
// One load-enabled storage word with synchronous active-high clear.
// Ports:
//   clk  in   clock
//   rst  in   synchronous clear, dominates the load enable
//   en   in   load enable
//   d    in   W  data to load
//   q    out  W  stored word
// ----------------------------------------------------------------------------
module regfile_sb_cell #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;

    // NOTE: register-file storage is cleared by reset here because reading
    // zeros from every register straight after reset is architectural, not
    // just a simulation nicety.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (en) begin
            data_q <= d;
        end
    end

    assign q = data_q;

endmodule : regfile_sb_cell

// File: rtl/regfile_sb.sv
// ----------------------------------------------------------------------------
// regfile_sb
// Register file with two combinational read ports, one write port with
// same-cycle bypass, and a busy-bit scoreboard for destination reservations.
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   ra_sel/rb_sel   in     read indices; ra_data/rb_data out read data
//   ra_busy/rb_busy out    selected register has a pending reservation
//   we, wsel, wdata in     write port
//   rsv_valid, rsv_sel in  reservation request; rsv_ready out acceptance
//   busy_vec  out          per-register busy bits
//   pend_cnt  out          number of busy registers (registered)
// ----------------------------------------------------------------------------
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int NREG = NREG_DEFAULT,
    parameter int W    = W_DEFAULT,
    parameter int SELW = SELW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SELW-1:0] ra_sel,
    input  logic [SELW-1:0] rb_sel,
    output logic [W-1:0]    ra_data,
    output logic [W-1:0]    rb_data,
    output logic            ra_busy,
    output logic            rb_busy,
    input  logic            we,
    input  logic [SELW-1:0] wsel,
    input  logic [W-1:0]    wdata,
    input  logic            rsv_valid,
    input  logic [SELW-1:0] rsv_sel,
    output logic            rsv_ready,
    output logic [NREG-1:0] busy_vec,
    output logic [SELW:0]   pend_cnt
);

    logic [W-1:0]    rf_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [SELW:0]   pend_q, pend_d;

    logic write_hit;     // write to an existing register
    logic rsv_accept;
    logic rsv_tgt_busy;  // busy bit of rsv_sel, 0 when out of range
    logic wr_tgt_busy;   // busy bit of wsel, 0 when out of range
    logic cnt_inc, cnt_dec;

    // Zero-extend the index before comparing so NREG = 2**SELW works.
    function automatic logic in_range(input logic [SELW-1:0] sel);
        return 32'(sel) < NREG;
    endfunction

    assign write_hit = we && in_range(wsel);

    // ------------------------------------------------------------------
    // Storage: one load-enabled cell per register.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NREG; i++) begin : g_cell
        regfile_sb_cell #(.W(W)) u_cell (
            .clk (clk),
            .rst (rst),
            .en  (write_hit && (wsel == SELW'(i))),
            .d   (wdata),
            .q   (rf_q[i])
        );
    end

    // ------------------------------------------------------------------
    // Read ports with write bypass. A bypassed read sees the value being
    // written, which by definition is no longer pending, so busy reads 0.
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        ra_data      = '0;
        rb_data      = '0;
        ra_busy      = 1'b0;
        rb_busy      = 1'b0;
        rsv_tgt_busy = 1'b0;
        wr_tgt_busy  = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (ra_sel == SELW'(i)) begin
                ra_data = rf_q[i];
                ra_busy = busy_q[i];
            end
            if (rb_sel == SELW'(i)) begin
                rb_data = rf_q[i];
                rb_busy = busy_q[i];
            end
            if (rsv_sel == SELW'(i)) rsv_tgt_busy = busy_q[i];
            if (wsel    == SELW'(i)) wr_tgt_busy  = busy_q[i];
        end
        if (write_hit && (wsel == ra_sel)) begin
            ra_data = wdata;
            ra_busy = 1'b0;
        end
        if (write_hit && (wsel == rb_sel)) begin
            rb_data = wdata;
            rb_busy = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard. A busy register may be re-reserved only by the same
    // cycle's write retiring it.
    // ------------------------------------------------------------------
    assign rsv_ready  = in_range(rsv_sel) &&
                        (!rsv_tgt_busy || (we && (wsel == rsv_sel)));
    assign rsv_accept = rsv_valid && rsv_ready;

    // Count moves only when a bit actually flips: an accept sets a clear
    // bit unless it was busy (then the write retires and re-reserves it),
    // and a write clears a set bit unless the reserve to the same register
    // re-sets it.
    assign cnt_inc = rsv_accept && !rsv_tgt_busy;
    assign cnt_dec = write_hit && wr_tgt_busy &&
                     !(rsv_accept && (rsv_sel == wsel));

    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NREG; i++) begin
            if (write_hit  && (wsel    == SELW'(i))) busy_d[i] = 1'b0;
            // Applied after the write clear so a same-register reserve wins.
            if (rsv_accept && (rsv_sel == SELW'(i))) busy_d[i] = 1'b1;
        end

        unique case ({cnt_inc, cnt_dec})
            2'b10:   pend_d = pend_q + 1'b1;
            2'b01:   pend_d = pend_q - 1'b1;
            default: pend_d = pend_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    assign busy_vec = busy_q;
    assign pend_cnt = pend_q;

endmodule : regfile_sb
